mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one memory-controller request port among NUM_REQ masters.
//  Typical masters: fetch, load/store, DMA/debug.
//  Sits between the masters and the memory controller's data port (enable/valid, 25-bit addr, oplen).
//  Registers the winning request, holds it until the downstream handshake completes,
//  then returns the result to the granted master.
// PARAMETERS
//  NUM_REQ         3     number of masters, 2..8
//  TIMEOUT_CYCLES  1024  BUSY cycles before abort (only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1              clock, all logic on posedge
//  rst_n         in   1              synchronous, active-low reset
//  req_enable    in   NUM_REQ        per-master request, held high until req_valid
//  req_we        in   NUM_REQ        per-master write enable
//  req_unsigned  in   NUM_REQ        per-master zero-extend select for loads
//  req_oplen     in   NUM_REQ x 2    per-master access size: 0=byte, 1=half, 2=3 bytes, 3=word
//  req_addr      in   NUM_REQ x 25   per-master byte address
//  req_wdata     in   NUM_REQ x 32   per-master write data
//  req_valid     out  NUM_REQ        one-cycle completion pulse to the granted master
//  req_error     out  NUM_REQ        one-cycle abort pulse, coincident with req_valid
//  req_result    out  32             shared read data; meaningful only while req_valid
//  m_enable      out  1              downstream request
//  m_valid       in   1              downstream completion
//  m_addr        out  25             downstream address
//  m_oplen       out  2              downstream access size
//  m_unsigned    out  1              downstream zero-extend select
//  m_we          out  1              downstream write enable
//  m_wdata       out  32             downstream write data
//  m_result      in   32             downstream read data
//  grant_idx     out  GW             current/last grantee; GW = max(1, $clog2(NUM_REQ))
//  busy          out  1              high in ISSUE/BUSY/DONE
// BEHAVIOUR
//  Reset:
//   - all outputs 0; last_grant = NUM_REQ-1, so master 0 wins first; state IDLE.
//   - reset mid-transaction: m_enable low at the next edge; no req_valid issued.
//  FSM IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
//   - IDLE: eligible = req_enable & ~holdoff_mask; proceed only if eligible != 0 and m_valid == 0.
//     Winner = first set bit scanning from last_grant+1 with wrap-around.
//     Latch the winner's addr/oplen/unsigned/we/wdata into regs; grant_idx <= winner; -> ISSUE.
//   - ISSUE: m_enable = 1, m_* driven from the latched regs; -> BUSY.
//   - BUSY: m_enable held 1, m_* stable.
//     On m_valid: req_result <= m_result; last_grant <= grant_idx; -> DONE.
//   - DONE: m_enable = 0; req_valid[grant_idx] = 1 for exactly this cycle; -> IDLE.
//  Latency: request seen in IDLE -> m_enable 1 cycle later; m_valid -> req_valid 1 cycle later.
//   Minimum total with a zero-wait downstream: 4 cycles.
//  Holdoff:
//   - in the first IDLE cycle after DONE, the previous grantee is masked (holdoff_mask).
//   - masters must drop req_enable the cycle after req_valid; otherwise they are re-served later.
//  Rules:
//   - req_enable withdrawn during ISSUE/BUSY is ignored; the transaction completes and req_valid still pulses.
//   - Latched fields never change while m_enable = 1.
//   - Requests arriving while busy wait; no queueing beyond the per-master level.
//   - Only one req_valid bit is ever high; req_result holds its value between completions.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - 16-bit counter cleared in ISSUE, incremented in BUSY.
//   - At TIMEOUT_CYCLES-1 without m_valid: abort to DONE with req_error[g] = 1 and
//     req_result = 32'hDEAD_BEEF; m_enable drops.
//   - m_valid in the same cycle as expiry wins: normal completion, no error.
//  MEM_ARB_TIMEOUT_EN undefined: no counter; req_error tied 0; BUSY waits indefinitely.
// STRUCTURE
//  mem_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} arb_state_t;
//   - typedef struct packed {addr[24:0], oplen[1:0], usgn, we, wdata[31:0]} mem_req_t;
//   - localparam DEAD_RESULT = 32'hDEAD_BEEF.
//  Sub-module mem_arb_rr_pick: combinational.
//   - inputs: eligible[NUM_REQ], last_grant.
//   - outputs: winner index, any.
// TESTING
//  1. Reset, req_enable = 3'b001, addr 0x40, zero-wait downstream
//     -> m_enable at cycle+1 with m_addr 0x40; req_valid[0] one cycle after m_valid.
//  2. req_enable = 3'b111 held, masters drop after valid
//     -> grant order 0,1,2, then 0 again on re-request; never two req_valid bits together.
//  3. Master 1 drops req_enable mid-BUSY
//     -> transaction completes; req_valid[1] pulses; m_addr stable throughout.
//  4. Master 0 keeps req_enable high after valid, master 2 requests
//     -> master 2 is granted next (holdoff + rotation).
//  5. TIMEOUT_EN, TIMEOUT_CYCLES = 8, m_valid never rises
//     -> req_valid[g] = req_error[g] = 1, req_result 0xDEADBEEF, m_enable low.
//     Same setup with m_valid at expiry -> no error.
//  6. rst_n low while BUSY -> m_enable 0 next edge, no req_valid; after reset master 0 wins first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} arb_state_t;

    typedef struct packed {
        logic [24:0] addr;
        logic [1:0]  oplen;
        logic        usgn;
        logic        we;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [31:0] DEAD_RESULT = 32'hDEAD_BEEF;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin pick: first eligible master after i_last_grant, wrapping.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int GW      = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [GW-1:0]      i_last_grant,
    output logic [GW-1:0]      o_winner,
    output logic               o_any
);

    int w_cand;

    // Scan farthest-first so the closest eligible master overwrites earlier hits.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_cand   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = int'(i_last_grant) + k;
            if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
            if (i_eligible[GW'(w_cand)]) begin
                o_winner = GW'(w_cand);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among NUM_REQ masters.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 3,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int GW             = grant_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       i_req_enable,
    input  logic [NUM_REQ-1:0]       i_req_we,
    input  logic [NUM_REQ-1:0]       i_req_unsigned,
    input  logic [NUM_REQ-1:0][1:0]  i_req_oplen,
    input  logic [NUM_REQ-1:0][24:0] i_req_addr,
    input  logic [NUM_REQ-1:0][31:0] i_req_wdata,
    output logic [NUM_REQ-1:0]       o_req_valid,
    output logic [NUM_REQ-1:0]       o_req_error,
    output logic [31:0]              o_req_result,
    output logic                     o_m_enable,
    input  logic                     i_m_valid,
    output logic [24:0]              o_m_addr,
    output logic [1:0]               o_m_oplen,
    output logic                     o_m_unsigned,
    output logic                     o_m_we,
    output logic [31:0]              o_m_wdata,
    input  logic [31:0]              i_m_result,
    output logic [GW-1:0]            o_grant_idx,
    output logic                     o_busy
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_param
        $error("mem_port_arbiter: parameter out of range");
    end

    arb_state_t          r_state, w_next;
    mem_req_t            r_req, w_sel;
    logic [GW-1:0]       r_grant, r_last, w_winner;
    logic                r_holdoff, w_any, w_latch, w_done, w_abort;
    logic [31:0]         r_result;
    logic [NUM_REQ-1:0]  w_mask, w_gnt_oh;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0]         r_tmo;
    logic                r_err;
`endif

    // The previous grantee sits out the first IDLE cycle after its completion.
    always_comb begin
        w_mask = '0;
        if (r_holdoff) w_mask[r_grant] = 1'b1;
        w_gnt_oh = '0;
        w_gnt_oh[r_grant] = 1'b1;
    end

    mem_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_eligible   (i_req_enable & ~w_mask),
        .i_last_grant (r_last),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

    always_comb begin
        w_sel.addr  = i_req_addr[w_winner];
        w_sel.oplen = i_req_oplen[w_winner];
        w_sel.usgn  = i_req_unsigned[w_winner];
        w_sel.we    = i_req_we[w_winner];
        w_sel.wdata = i_req_wdata[w_winner];
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            IDLE:  if (w_any && !i_m_valid) begin
                       w_next  = ISSUE;
                       w_latch = 1'b1;
                   end
            ISSUE: w_next = BUSY;
            BUSY:  if (i_m_valid) begin
                       w_next = DONE;
                       w_done = 1'b1;
                   end
`ifdef MEM_ARB_TIMEOUT_EN
                   else if (r_tmo == 16'(TIMEOUT_CYCLES - 1)) begin
                       w_next  = DONE;
                       w_abort = 1'b1;
                   end
`endif
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_req     <= '0;
            r_grant   <= '0;
            r_last    <= GW'(NUM_REQ - 1);
            r_holdoff <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state   <= w_next;
            r_holdoff <= (r_state == DONE);
            if (w_latch) begin
                r_req   <= w_sel;
                r_grant <= w_winner;
            end
            if (w_done) begin
                r_result <= i_m_result;
                r_last   <= r_grant;
            end
            if (w_abort) begin
                r_result <= DEAD_RESULT;
                r_last   <= r_grant;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (r_state == ISSUE)     r_tmo <= '0;
            else if (r_state == BUSY) r_tmo <= r_tmo + 16'd1;
        end
    end

    assign o_req_error = (r_state == DONE && r_err) ? w_gnt_oh : '0;
`else
    assign o_req_error = '0;
`endif

    assign o_m_enable   = (r_state == ISSUE) || (r_state == BUSY);
    assign o_m_addr     = r_req.addr;
    assign o_m_oplen    = r_req.oplen;
    assign o_m_unsigned = r_req.usgn;
    assign o_m_we       = r_req.we;
    assign o_m_wdata    = r_req.wdata;
    assign o_req_valid  = (r_state == DONE) ? w_gnt_oh : '0;
    assign o_req_result = r_result;
    assign o_grant_idx  = r_grant;
    assign o_busy       = (r_state != IDLE);

endmodule
